fft_deserializer: RTL and testbench
===================================

// Module: fft_deserializer
// PURPOSE
//  Serial-to-parallel front end of the 4-lane parallel FFT. Accepts one complex sample per
//  valid cycle and packs each 32-sample frame into 8 words of 4 lanes. It then emits those
//  8 words as a contiguous burst into the FFT input. Serial-sample order is
//  word0{ch0,ch1,ch2,ch3}, word1{ch0..ch3}, ... word7, so sample n maps to word n/4, lane n%4.
//  Uses a ping-pong frame buffer so input streaming never stalls during a burst.
// PARAMETERS
//  NB_DATA   12   bits per real/imag part; one sample is {re,im}, 2*NB_DATA bits
// PORTS
//  i_clk        in   1           clock
//  i_rst        in   1           synchronous, active-high reset
//  i_enable     in   1           clock enable; low freezes all state and outputs
//  i_valid      in   1           i_din carries a sample this cycle
//  i_sof        in   1           qualified by i_valid: this sample is frame sample 0
//  i_din        in   2*NB_DATA   serial sample {re,im}
//  o_dout_ch0   out  2*NB_DATA   lane 0 of current word (sample 4w+0)
//  o_dout_ch1   out  2*NB_DATA   lane 1 (4w+1)
//  o_dout_ch2   out  2*NB_DATA   lane 2 (4w+2)
//  o_dout_ch3   out  2*NB_DATA   lane 3 (4w+3)
//  o_valid      out  1           output word valid; high for exactly 8 consecutive enabled cycles per frame
//  o_sof        out  1           high with word 0 of each burst
//  o_frame_err  out  1           1-cycle pulse: partial frame discarded by early i_sof
// BEHAVIOUR
//  - Reset: all outputs 0, both banks empty, write bank 0, write count 0, read FSM IDLE.
//  - Write side: 5-bit sample counter wr_cnt and 1-bit wr_bank.
//    - Each accepted sample (i_valid & i_enable) is stored at bank[wr_bank][wr_cnt>>2][wr_cnt&3].
//    - Before the first i_sof after reset, samples are dropped (unsynced).
//    - i_sof with wr_cnt!=0 discards the partial frame: pulse o_frame_err, store the sample
//      at index 0, wr_cnt=1.
//    - i_sof with wr_cnt==0 is a normal frame start.
//    - On the 32nd sample (wr_cnt==31): set full[wr_bank], toggle wr_bank, wr_cnt=0. The next
//      frame must again start with i_sof; samples without sof at wr_cnt==0 are dropped.
//  - Read FSM: IDLE -> BURST when full[rd_bank].
//    - BURST emits words 0..7 one per enabled cycle.
//    - After word 7: clear full[rd_bank], toggle rd_bank, return to IDLE; go straight back
//      to BURST if the other bank is already full.
//  - Latency: sample 31 accepted at edge t -> word 0 on outputs after edge t+2, when the
//    read side is idle. Outputs are registered.
//  - o_dout_* hold their last value when o_valid=0.
//  - Overflow cannot occur at <=1 sample/cycle: a burst takes 8 cycles, a fill takes >=32.
//    The write side still checks full[wr_bank]; a frame aimed at a full bank is dropped
//    with an o_frame_err pulse.
//  - Simultaneous events:
//    - Set-full and clear-full on different banks in the same cycle both take effect.
//    - sof on the same cycle that completes a frame is impossible (wr_cnt==31 vs sof).
//  - i_rst mid-burst: o_valid=0 after the reset edge, remaining words are lost, state is
//    restored to reset values.
//  - i_enable=0: no sample accepted, FSM and counters hold, outputs hold (o_valid keeps
//    its value; a downstream consumer must gate with the same enable).
// STRUCTURE
//  - Package fft_par_pkg: N_LANES=4, N_WORDS=8, FRAME_LEN=32, the sample width function
//    2*NB_DATA, and the read FSM state enum {IDLE,BURST}.
//  - Sub-module fft_deser_bank: one frame store, 8 words x 4 lanes. Write port is
//    sample-addressed (5b); read port is word-addressed (3b) with registered 4-lane
//    output. Instantiated twice (ping-pong).
//  - Top holds the write counter, the bank-full flags, the read FSM and the output muxing.
// TESTING
//  1. Reset, then samples 0..31 (value=index), sof on 0 -> word w lanes = 4w..4w+3;
//     o_valid high 8 cycles starting 2 cycles after sample 31; o_sof on word 0 only.
//  2. 64 samples back-to-back, sof at 0 and 32 -> two bursts 32 cycles apart.
//     Second burst carries 32..63; banks alternate; o_frame_err never asserted.
//  3. i_valid every other cycle, 32 samples -> identical words to test 1; burst still
//     8 consecutive cycles.
//  4. sof, 10 samples, sof again, 32 samples -> o_frame_err one pulse at the second sof.
//     Burst holds only the 32 post-sof samples.
//  5. i_rst asserted while word 3 is on the outputs -> o_valid=0 next cycle, no words 4..7.
//     A following clean frame behaves as test 1.
//  6. i_enable low 5 cycles during word 2 -> outputs frozen at word 2. Burst resumes with
//     word 3; order and data are intact.

Source files
------------

// File: rtl/fft_par_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fft_par_pkg
//  Description : Shared constants, helper function and read-FSM state type
//                for the 4-lane parallel FFT front end.
//  Revision    : 1.0 - initial release
// ============================================================================
package fft_par_pkg;

    localparam int N_LANES   = 4;
    localparam int N_WORDS   = 8;
    localparam int FRAME_LEN = 32;

    localparam int LANE_AW   = 2;   // log2(N_LANES)
    localparam int WORD_AW   = 3;   // log2(N_WORDS)
    localparam int SAMPLE_AW = 5;   // log2(FRAME_LEN)

    // One complex sample is {re,im}.
    function automatic int sample_width(input int nb_data);
        return 2 * nb_data;
    endfunction

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } rd_state_e;

endpackage
`default_nettype wire

// File: rtl/fft_deser_bank.sv
`default_nettype none
// ============================================================================
//  Module      : fft_deser_bank
//  Description : One frame store of 8 words x 4 lanes. Sample-addressed write
//                port, word-addressed read port with a registered 4-lane
//                output that holds its value while i_re is low.
//  Ports       : i_clk    clock
//                i_we     write strobe      i_waddr  sample index (0..31)
//                i_wdata  sample {re,im}
//                i_re     read strobe       i_raddr  word index (0..7)
//                o_rdata  4 lanes of the word read on the last i_re
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_deser_bank
    import fft_par_pkg::*;
#(
    parameter int W = 24
) (
    input  logic                         i_clk,
    input  logic                         i_we,
    input  logic [SAMPLE_AW-1:0]         i_waddr,
    input  logic [W-1:0]                 i_wdata,
    input  logic                         i_re,
    input  logic [WORD_AW-1:0]           i_raddr,
    output logic [N_LANES-1:0][W-1:0]    o_rdata
);

    logic [W-1:0]              mem_q [FRAME_LEN];
    logic [N_LANES-1:0][W-1:0] rdata_q;

    always_ff @(posedge i_clk) begin
        if (i_we) begin
            mem_q[i_waddr] <= i_wdata;
        end
    end

    // Sample n lives at word n/4, lane n%4, so {word,lane} is the sample index.
    always_ff @(posedge i_clk) begin
        if (i_re) begin
            for (int l = 0; l < N_LANES; l++) begin
                rdata_q[l] <= mem_q[{i_raddr, LANE_AW'(l)}];
            end
        end
    end

    assign o_rdata = rdata_q;

endmodule
`default_nettype wire

// File: rtl/fft_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : fft_deserializer
//  Description : Serial-to-parallel front end of the 4-lane FFT. Packs each
//                32-sample frame into a ping-pong bank and bursts it out as 8
//                consecutive 4-lane words.
//  Ports       : i_clk, i_rst (sync, active-high), i_enable (clock enable)
//                i_valid/i_sof/i_din          serial sample input
//                o_dout_ch0..3                lanes of the current word
//                o_valid/o_sof                word valid / word 0 marker
//                o_frame_err                  partial or dropped frame pulse
//  Revision    : 1.0 - initial release
// ============================================================================
module fft_deserializer
    import fft_par_pkg::*;
#(
    parameter int NB_DATA = 12
) (
    input  logic                              i_clk,
    input  logic                              i_rst,
    input  logic                              i_enable,
    input  logic                              i_valid,
    input  logic                              i_sof,
    input  logic [sample_width(NB_DATA)-1:0]  i_din,
    output logic [sample_width(NB_DATA)-1:0]  o_dout_ch0,
    output logic [sample_width(NB_DATA)-1:0]  o_dout_ch1,
    output logic [sample_width(NB_DATA)-1:0]  o_dout_ch2,
    output logic [sample_width(NB_DATA)-1:0]  o_dout_ch3,
    output logic                              o_valid,
    output logic                              o_sof,
    output logic                              o_frame_err
);

    localparam int W = sample_width(NB_DATA);

    // Write side
    logic [SAMPLE_AW-1:0] wr_cnt_q, wr_cnt_d;
    logic                 wr_bank_q, wr_bank_d;
    logic [1:0]           full_q, full_d;
    logic                 wr_en, set_full, frame_err_d;
    logic [SAMPLE_AW-1:0] wr_addr;

    // Read side
    rd_state_e            state_q, state_d;
    logic [WORD_AW-1:0]   rd_cnt_q, rd_cnt_d;
    logic                 rd_bank_q, rd_bank_d;
    logic                 rd_issue, issue_sof, clr_full;
    logic                 rd_vld_q, rd_sof_q, rd_sel_q;

    // Output registers
    logic [N_LANES-1:0][W-1:0] dout_q;
    logic                      valid_q, sof_q, frame_err_q;

    logic [N_LANES-1:0][W-1:0] bank_rdata [2];

    // A sample at wr_cnt==0 is only accepted with i_sof, which also covers the
    // unsynced period after reset.
    always_comb begin
        wr_cnt_d    = wr_cnt_q;
        wr_bank_d   = wr_bank_q;
        wr_en       = 1'b0;
        wr_addr     = wr_cnt_q;
        set_full    = 1'b0;
        frame_err_d = 1'b0;
        if (i_enable && i_valid) begin
            if (i_sof) begin
                if (full_q[wr_bank_q]) begin
                    // Target bank still awaiting readout: drop the whole frame.
                    frame_err_d = 1'b1;
                    wr_cnt_d    = '0;
                end else begin
                    frame_err_d = (wr_cnt_q != '0);
                    wr_en       = 1'b1;
                    wr_addr     = '0;
                    wr_cnt_d    = SAMPLE_AW'(1);
                end
            end else if (wr_cnt_q != '0) begin
                wr_en = 1'b1;
                if (wr_cnt_q == SAMPLE_AW'(FRAME_LEN - 1)) begin
                    set_full  = 1'b1;
                    wr_bank_d = ~wr_bank_q;
                    wr_cnt_d  = '0;
                end else begin
                    wr_cnt_d = wr_cnt_q + SAMPLE_AW'(1);
                end
            end
        end
    end

    // Read FSM. Word 0 is issued from IDLE on the same cycle the full flag is
    // seen, so a back-to-back frame follows word 7 without a bubble.
    always_comb begin
        state_d   = state_q;
        rd_cnt_d  = rd_cnt_q;
        rd_bank_d = rd_bank_q;
        rd_issue  = 1'b0;
        issue_sof = 1'b0;
        clr_full  = 1'b0;
        if (i_enable) begin
            case (state_q)
                IDLE: begin
                    if (full_q[rd_bank_q]) begin
                        rd_issue  = 1'b1;
                        issue_sof = 1'b1;
                        rd_cnt_d  = WORD_AW'(1);
                        state_d   = BURST;
                    end
                end
                BURST: begin
                    rd_issue = 1'b1;
                    if (rd_cnt_q == WORD_AW'(N_WORDS - 1)) begin
                        clr_full  = 1'b1;
                        rd_bank_d = ~rd_bank_q;
                        rd_cnt_d  = '0;
                        state_d   = IDLE;
                    end else begin
                        rd_cnt_d = rd_cnt_q + WORD_AW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // Set and clear always address different banks, so both apply.
    always_comb begin
        full_d = full_q;
        if (set_full) full_d[wr_bank_q] = 1'b1;
        if (clr_full) full_d[rd_bank_q] = 1'b0;
    end

    generate
        for (genvar b = 0; b < 2; b++) begin : g_bank
            fft_deser_bank #(
                .W (W)
            ) u_bank (
                .i_clk   (i_clk),
                .i_we    (wr_en && (wr_bank_q == 1'(b))),
                .i_waddr (wr_addr),
                .i_wdata (i_din),
                .i_re    (rd_issue && (rd_bank_q == 1'(b))),
                .i_raddr (rd_cnt_q),
                .o_rdata (bank_rdata[b])
            );
        end
    endgenerate

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_cnt_q    <= '0;
            wr_bank_q   <= 1'b0;
            full_q      <= '0;
            state_q     <= IDLE;
            rd_cnt_q    <= '0;
            rd_bank_q   <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_sof_q    <= 1'b0;
            rd_sel_q    <= 1'b0;
            dout_q      <= '0;
            valid_q     <= 1'b0;
            sof_q       <= 1'b0;
            frame_err_q <= 1'b0;
        end else if (i_enable) begin
            wr_cnt_q    <= wr_cnt_d;
            wr_bank_q   <= wr_bank_d;
            full_q      <= full_d;
            state_q     <= state_d;
            rd_cnt_q    <= rd_cnt_d;
            rd_bank_q   <= rd_bank_d;
            rd_vld_q    <= rd_issue;
            rd_sof_q    <= issue_sof;
            rd_sel_q    <= rd_bank_q;
            valid_q     <= rd_vld_q;
            sof_q       <= rd_sof_q;
            frame_err_q <= frame_err_d;
            if (rd_vld_q) begin
                dout_q <= rd_sel_q ? bank_rdata[1] : bank_rdata[0];
            end
        end
    end

    assign o_dout_ch0  = dout_q[0];
    assign o_dout_ch1  = dout_q[1];
    assign o_dout_ch2  = dout_q[2];
    assign o_dout_ch3  = dout_q[3];
    assign o_valid     = valid_q;
    assign o_sof       = sof_q;
    assign o_frame_err = frame_err_q;

endmodule
`default_nettype wire

// File: tb/tb_fft_deserializer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fft_deserializer
//  Description : Directed self-checking bench for fft_deserializer. Expected
//                words are queued when a frame completes and popped by a
//                monitor as the burst appears.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fft_deserializer;

    localparam int NB = 12;
    localparam int W  = 2 * NB;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_enable;
    logic         i_valid;
    logic         i_sof;
    logic [W-1:0] i_din;
    logic [W-1:0] o_dout_ch0, o_dout_ch1, o_dout_ch2, o_dout_ch3;
    logic         o_valid, o_sof, o_frame_err;

    fft_deserializer #(.NB_DATA(NB)) dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_enable    (i_enable),
        .i_valid     (i_valid),
        .i_sof       (i_sof),
        .i_din       (i_din),
        .o_dout_ch0  (o_dout_ch0),
        .o_dout_ch1  (o_dout_ch1),
        .o_dout_ch2  (o_dout_ch2),
        .o_dout_ch3  (o_dout_ch3),
        .o_valid     (o_valid),
        .o_sof       (o_sof),
        .o_frame_err (o_frame_err)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0;
    int errors = 0;

    logic [96:0] exp_q [$];
    int cyc = 0;
    logic en_last = 1'b0;
    logic rst_last = 1'b1;
    int run = 0;
    int last_sof = -1;
    int prev_sof = -1;
    int err_pulses = 0;
    int err_cyc = -1;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] val(input int n);
        logic [11:0] re, im;
        re = 12'(n * 3 + 7);
        im = 12'(n);
        return {re, im};
    endfunction

    function automatic logic [96:0] exp_word(input int base, input int w);
        return {(w == 0), val(base + 4*w), val(base + 4*w + 1),
                val(base + 4*w + 2), val(base + 4*w + 3)};
    endfunction

    always @(posedge i_clk) begin
        cyc      <= cyc + 1;
        en_last  <= i_enable;
        rst_last <= i_rst;
    end

    // Monitor: a new output word exists only after an enabled, non-reset edge.
    always @(negedge i_clk) begin
        logic [96:0] e;
        if (rst_last) begin
            run = 0;
        end else if (en_last) begin
            if (o_valid) begin
                run++;
                chk("unexpected_word", 128'(exp_q.size() > 0), 128'(1));
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("word", 128'({o_sof, o_dout_ch0, o_dout_ch1, o_dout_ch2, o_dout_ch3}),
                        128'(e));
                end
                if (o_sof) begin
                    prev_sof = last_sof;
                    last_sof = cyc;
                end
            end else if (run != 0) begin
                chk("burst_len_mod8", 128'(run % 8), 128'(0));
                run = 0;
            end
            if (o_frame_err) begin
                err_pulses++;
                err_cyc = cyc;
            end
        end
    end

    // Sends one full frame; acc0/acc31 are the cycle numbers of acceptance of
    // samples 0 and 31.
    task automatic send_frame(input int base, input int gap, output int acc0, output int acc31);
        acc0  = 0;
        acc31 = 0;
        for (int n = 0; n < 32; n++) begin
            i_valid = 1'b1;
            i_sof   = (n == 0);
            i_din   = val(base + n);
            @(negedge i_clk);
            i_valid = 1'b0;
            i_sof   = 1'b0;
            if (n == 0) acc0 = cyc;
            if (n == 31) begin
                acc31 = cyc;
                for (int w = 0; w < 8; w++) exp_q.push_back(exp_word(base, w));
            end else begin
                repeat (gap) @(negedge i_clk);
            end
        end
    endtask

    task automatic drain(input string tag);
        for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(negedge i_clk);
        chk(tag, 128'(exp_q.size()), 128'(0));
    endtask

    initial begin
        int a0, a31, b0, b31;
        i_rst = 1'b1; i_enable = 1'b1; i_valid = 1'b0; i_sof = 1'b0; i_din = '0;
        repeat (3) @(negedge i_clk);
        chk("reset_outputs",
            128'({o_valid, o_sof, o_frame_err, o_dout_ch0, o_dout_ch1, o_dout_ch2, o_dout_ch3}),
            128'(0));
        i_rst = 1'b0;

        // Test 1: unsynced samples are dropped, then a clean frame.
        for (int n = 0; n < 3; n++) begin
            i_valid = 1'b1; i_din = val(900 + n);
            @(negedge i_clk);
        end
        i_valid = 1'b0;
        send_frame(0, 0, a0, a31);
        drain("t1_drain");
        chk("t1_latency", 128'(last_sof - a31), 128'(2));

        // Test 2: two frames back-to-back.
        send_frame(100, 0, a0, a31);
        send_frame(132, 0, b0, b31);
        drain("t2_drain");
        chk("t2_burst_spacing", 128'(last_sof - prev_sof), 128'(32));
        chk("t2_no_frame_err", 128'(err_pulses), 128'(0));

        // Test 3: valid every other cycle.
        send_frame(0, 1, a0, a31);
        drain("t3_drain");
        chk("t3_latency", 128'(last_sof - a31), 128'(2));

        // Test 4: partial frame cut short by a new sof.
        for (int n = 0; n < 10; n++) begin
            i_valid = 1'b1; i_sof = (n == 0); i_din = val(150 + n);
            @(negedge i_clk);
        end
        i_valid = 1'b0; i_sof = 1'b0;
        send_frame(200, 0, a0, a31);
        drain("t4_drain");
        chk("t4_err_count", 128'(err_pulses), 128'(1));
        chk("t4_err_timing", 128'(err_cyc), 128'(a0));

        // Test 5: reset while word 3 is on the outputs.
        send_frame(300, 0, a0, a31);
        repeat (5) @(negedge i_clk);
        chk("t5_word3_shown", 128'({o_valid, o_dout_ch0}), 128'({1'b1, val(312)}));
        i_rst = 1'b1;
        @(negedge i_clk);
        chk("t5_valid_after_rst", 128'(o_valid), 128'(0));
        exp_q.delete();
        i_rst = 1'b0;
        repeat (15) @(negedge i_clk);
        chk("t5_no_stray", 128'(o_valid), 128'(0));
        send_frame(400, 0, a0, a31);
        drain("t5_drain");
        chk("t5_latency", 128'(last_sof - a31), 128'(2));

        // Test 6: enable low for 5 cycles while word 2 is shown.
        send_frame(500, 0, a0, a31);
        repeat (4) @(negedge i_clk);
        chk("t6_word2_shown", 128'({o_valid, o_dout_ch1}), 128'({1'b1, val(509)}));
        i_enable = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge i_clk);
            chk("t6_frozen", 128'({o_valid, o_sof, o_dout_ch0, o_dout_ch3}),
                128'({1'b1, 1'b0, val(508), val(511)}));
        end
        i_enable = 1'b1;
        drain("t6_drain");
        chk("t6_err_count", 128'(err_pulses), 128'(1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
